axi_sram_bridge_mp: RTL and testbench
=====================================

// Module: axi_sram_bridge_mp
// PURPOSE
//  Parametrised N-port SRAM-like to AXI3 master bridge; sits between CPU/cache ports and the AXI interconnect.
//  Supports up to MAX_OUT outstanding reads per port, routed back by rid, plus one outstanding write.
//  Read issue is blocked by a word-address RAW check against the pending write.
//  Port N_PORTS-1 has highest priority.
// PARAMETERS
//  N_PORTS  2  number of SRAM-like ports, 1..16; port index is used as AXI id
//  MAX_OUT  4  max outstanding reads per port, 1..15
// PORTS
//  clk             in   1        single clock, all logic on posedge
//  reset           in   1        synchronous, active-high
//  sram_req        in   N        per-port request
//  sram_wr         in   N        1 = write, 0 = read
//  sram_size       in   2N       log2 bytes (0/1/2), port i at [2i+1:2i]
//  sram_addr       in   32N      byte address, port i at [32i+31:32i]
//  sram_wstrb      in   4N       byte enables (writes only)
//  sram_wdata      in   32N      write data
//  sram_addr_ok    out  N        request accepted this cycle
//  sram_data_ok    out  N        read data valid / write response done
//  sram_rdata      out  32       shared read data; qualified by sram_data_ok[i]
//  ar*/r*/aw*/w*/b*  AXI3 master channels, standard widths (id 4, data 32)
// BEHAVIOUR
//  Reset: arvalid=awvalid=wvalid=0; all outstanding counters=0; wr_busy=0; sram_addr_ok=sram_data_ok=0.
//  Constants: rready=bready=1; arlen=awlen=0; arburst=awburst=2'b01; lock/cache/prot=0; wlast=1; wid=awid.
//  Read eligibility for port i:
//   - req&~wr
//   - cnt[i]<MAX_OUT
//   - AR slot free (!arvalid || arready)
//   - no RAW hit, i.e. NOT (wr_busy && addr[31:2]==wr_addr[31:2])
//  Write eligibility for port i:
//   - req&wr
//   - !wr_busy
//   - !arvalid (ensures AR ordering before AW)
//  Arbitration:
//   - Among eligible ports only, so blocked ports never starve others.
//   - Exactly one grant per cycle.
//   - sram_addr_ok[i] = grant[i], combinational, same cycle.
//  Read accept:
//   - Next cycle arvalid=1, arid=i, araddr/arsize latched, cnt[i]++.
//   - Held stable until arready.
//   - Accept in the arready cycle is allowed (back-to-back AR).
//  Read return:
//   - sram_data_ok[rid]=rvalid; sram_rdata=rdata, combinational, 0-cycle.
//   - cnt[rid]-- on rvalid&rlast.
//   - Same-cycle inc and dec on one port: count unchanged.
//   - rid>=N_PORTS: data dropped, no data_ok.
//  Write accept:
//   - Next cycle awvalid=wvalid=1, wr_busy=1.
//   - addr/size/strb/data/id latched.
//   - AW and W drop independently on their own ready.
//   - bvalid: sram_data_ok[bid]=1, wr_busy=0.
//   - New write is accepted no earlier than the cycle after bvalid.
//  Size: arsize/awsize={1'b0,size}; size 3 is treated as 2.
//  rresp/bresp ignored.
//  Reset mid-operation: all state cleared. In-flight AXI responses after reset are dropped, since counters are 0 and no data_ok is produced for cnt==0 ports.
// CONFIGURATION
//  AXI_BRIDGE_RR_ARB_EN defined:
//   - Round-robin arbitration.
//   - Pointer advances to (granted index+1) mod N_PORTS after each grant; reset pointer=0.
//  Undefined: fixed priority, highest index wins.
// TESTING
//  1. Reset then idle: arvalid/awvalid/wvalid=0, rready=bready=1, addr_ok=0.
//  2. Port1 read 0x1000:
//     - addr_ok[1] same cycle.
//     - Next cycle arvalid, arid=1, araddr=0x1000.
//     - rvalid rid=1 rdata=0xDEADBEEF -> data_ok[1], sram_rdata=0xDEADBEEF.
//  3. Port0 issues 5 reads, MAX_OUT=4, no R returns -> 4 addr_ok, 5th held until one rlast with rid=0.
//  4. Port1 write 0x2000 pending; port0 read 0x2002 -> blocked until bvalid bid=1. Read 0x3000 -> accepted.
//  5. Both ports read each cycle:
//     - Fixed: port1 always granted.
//     - RR_ARB_EN: grants alternate 1,0,1,0.
//  6. awready delayed 3 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid holds; data_ok only on bvalid.

Source files
------------

// File: rtl/axi_sram_bridge_mp.sv
// N-port SRAM-like to AXI3 master bridge: per-port outstanding reads routed by id, one pending write.
// Define AXI_BRIDGE_RR_ARB_EN for round-robin arbitration; otherwise the highest eligible index wins.
module axi_sram_bridge_mp #(
    parameter int N_PORTS = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     sram_req,
    input  logic [N_PORTS-1:0]     sram_wr,
    input  logic [2*N_PORTS-1:0]   sram_size,
    input  logic [32*N_PORTS-1:0]  sram_addr,
    input  logic [4*N_PORTS-1:0]   sram_wstrb,
    input  logic [32*N_PORTS-1:0]  sram_wdata,
    output logic [N_PORTS-1:0]     sram_addr_ok,
    output logic [N_PORTS-1:0]     sram_data_ok,
    output logic [31:0]            sram_rdata,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [1:0]             arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [3:0]             rid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [3:0]             awid,
    output logic [31:0]            awaddr,
    output logic [3:0]             awlen,
    output logic [2:0]             awsize,
    output logic [1:0]             awburst,
    output logic [1:0]             awlock,
    output logic [3:0]             awcache,
    output logic [2:0]             awprot,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [3:0]             wid,
    output logic [31:0]            wdata,
    output logic [3:0]             wstrb,
    output logic                   wlast,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [3:0]             bid,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic [N_PORTS-1:0]   rd_elig, wr_elig, elig, grant;
    logic [N_PORTS-1:0]   raw_hit, rsp_rd, rsp_wr, rd_inc, rd_dec;
    logic [3*N_PORTS-1:0] port_size;
    logic [15:0]          elig_pad, grant_pad;
    logic                 gnt_any;
    logic [3:0]           gnt_idx;

    logic                 sel_wr;
    logic [31:0]          sel_addr, sel_data;
    logic [2:0]           sel_size;
    logic [3:0]           sel_strb;

    logic [3:0]  cnt_q [N_PORTS];
    logic [3:0]  cnt_d [N_PORTS];
    logic        arvalid_q, arvalid_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        wr_busy_q, wr_busy_d;
    logic [3:0]  wr_id_q, wr_id_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [2:0]  wr_size_q, wr_size_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [31:0] wr_data_q, wr_data_d;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : gen_port
            logic [1:0] sz;
            assign sz = sram_size[2*gi +: 2];
            // Size 3 is not a legal 32-bit transfer; clamp it to a word.
            assign port_size[3*gi +: 3] = (sz == 2'b11) ? 3'b010 : {1'b0, sz};
            assign raw_hit[gi] = wr_busy_q && (sram_addr[32*gi+2 +: 30] == wr_addr_q[31:2]);
            assign rd_elig[gi] = sram_req[gi] && !sram_wr[gi] && (cnt_q[gi] < MAX_CNT)
                                 && (!arvalid_q || arready) && !raw_hit[gi];
            assign wr_elig[gi] = sram_req[gi] && sram_wr[gi] && !wr_busy_q && !arvalid_q;
            // A response for a port with nothing outstanding is stale (e.g. issued before reset).
            assign rsp_rd[gi] = rvalid && (rid == 4'(gi)) && (cnt_q[gi] != 4'd0);
            assign rsp_wr[gi] = bvalid && wr_busy_q && (bid == 4'(gi));
            assign rd_inc[gi] = gnt_any && !sel_wr && (gnt_idx == 4'(gi));
            assign rd_dec[gi] = rsp_rd[gi] && rlast;
        end
    endgenerate

    assign elig         = rd_elig | wr_elig;
    assign elig_pad     = 16'(elig);
    assign grant        = grant_pad[N_PORTS-1:0];
    assign sram_addr_ok = grant;
    assign sram_data_ok = rsp_rd | rsp_wr;
    assign sram_rdata   = rdata;

`ifdef AXI_BRIDGE_RR_ARB_EN
    logic [3:0] ptr_q, ptr_d;
    logic [5:0] rr_idx;

    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = 4'd0;
        grant_pad = '0;
        ptr_d     = ptr_q;
        rr_idx    = 6'd0;
        for (int k = 0; k < N_PORTS; k++) begin
            rr_idx = {2'b00, ptr_q} + 6'(k);
            if (rr_idx >= 6'(N_PORTS)) rr_idx = rr_idx - 6'(N_PORTS);
            if (!gnt_any && elig_pad[rr_idx[3:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx[3:0];
            end
        end
        if (gnt_any) begin
            grant_pad[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == 4'(N_PORTS-1)) ? 4'd0 : gnt_idx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 4'd0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = 4'd0;
        grant_pad = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = 4'(k);
            end
        end
        if (gnt_any) grant_pad[gnt_idx] = 1'b1;
    end
`endif

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = 32'd0;
        sel_size = 3'd0;
        sel_strb = 4'd0;
        sel_data = 32'd0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (gnt_idx == 4'(k)) begin
                sel_wr   = sram_wr[k];
                sel_addr = sram_addr[32*k +: 32];
                sel_size = port_size[3*k +: 3];
                sel_strb = sram_wstrb[4*k +: 4];
                sel_data = sram_wdata[32*k +: 32];
            end
        end
    end

    always_comb begin
        arvalid_d = arvalid_q && !arready;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        wr_busy_d = wr_busy_q && !bvalid;
        wr_id_d   = wr_id_q;
        wr_addr_d = wr_addr_q;
        wr_size_d = wr_size_q;
        wr_strb_d = wr_strb_q;
        wr_data_d = wr_data_q;
        if (gnt_any && !sel_wr) begin
            arvalid_d = 1'b1;
            arid_d    = gnt_idx;
            araddr_d  = sel_addr;
            arsize_d  = sel_size;
        end
        if (gnt_any && sel_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wr_busy_d = 1'b1;
            wr_id_d   = gnt_idx;
            wr_addr_d = sel_addr;
            wr_size_d = sel_size;
            wr_strb_d = sel_strb;
            wr_data_d = sel_data;
        end
        for (int i = 0; i < N_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rd_inc[i] && !rd_dec[i])      cnt_d[i] = cnt_q[i] + 4'd1;
            else if (!rd_inc[i] && rd_dec[i]) cnt_d[i] = cnt_q[i] - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            arid_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arsize_q  <= 3'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wr_busy_q <= 1'b0;
            wr_id_q   <= 4'd0;
            wr_addr_q <= 32'd0;
            wr_size_q <= 3'd0;
            wr_strb_q <= 4'd0;
            wr_data_q <= 32'd0;
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= 4'd0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wr_busy_q <= wr_busy_d;
            wr_id_q   <= wr_id_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            wr_strb_q <= wr_strb_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = 4'd0;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = 1'b1;
    assign awid    = wr_id_q;
    assign awaddr  = wr_addr_q;
    assign awlen   = 4'd0;
    assign awsize  = wr_size_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;
    assign wid     = wr_id_q;
    assign wdata   = wr_data_q;
    assign wstrb   = wr_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = 1'b1;

    logic unused_sink;
    assign unused_sink = &{1'b0, rresp, bresp, grant_pad, elig_pad};

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp (N_PORTS=2, MAX_OUT=4) with AR/AW/W scoreboards.
module tb_axi_sram_bridge_mp;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [N-1:0]    sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [2*N-1:0]  sram_size;
    logic [32*N-1:0] sram_addr, sram_wdata;
    logic [4*N-1:0]  sram_wstrb;
    logic [31:0]     sram_rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;
    int exp_cnt [N];

    typedef logic [38:0] ar_t;   // {id, addr, size}
    typedef logic [40:0] w_t;    // {id, data, strb, last}
    ar_t exp_ar [$];
    ar_t exp_aw [$];
    w_t  exp_w  [$];

    int          s5_n;
    logic [N-1:0] s5_g [5];

    axi_sram_bridge_mp #(.N_PORTS(N), .MAX_OUT(4)) dut (
        .clk(clk), .reset(reset),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_addr(sram_addr), .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
        sram_req[p]            = req;
        sram_wr[p]             = wr;
        sram_size[2*p +: 2]    = sz;
        sram_addr[32*p +: 32]  = a;
        sram_wstrb[4*p +: 4]   = st;
        sram_wdata[32*p +: 32] = d;
    endtask

    task automatic exp_read(input int p, input logic [31:0] a, input logic [2:0] s);
        exp_ar.push_back({4'(p), a, s});
        exp_cnt[p]++;
    endtask

    task automatic exp_write(input int p, input logic [31:0] a, input logic [2:0] s,
                             input logic [3:0] st, input logic [31:0] d);
        exp_aw.push_back({4'(p), a, s});
        exp_w.push_back({4'(p), d, st, 1'b1});
    endtask

    // One R beat; data_ok is expected only for a valid id with reads outstanding.
    task automatic rd_beat(input int id, input logic [31:0] d);
        logic [N-1:0] e;
        e      = '0;
        rvalid = 1'b1;
        rid    = 4'(id);
        rdata  = d;
        rlast  = 1'b1;
        @(negedge clk);
        if (id < N && exp_cnt[id] > 0) begin
            e[id] = 1'b1;
            exp_cnt[id]--;
        end
        check($sformatf("rd_data_ok_id%0d", id), sram_data_ok, e);
        if (e != '0) check("rd_rdata", sram_rdata, d);
        next_cycle();
        rvalid = 1'b0;
    endtask

    task automatic drain(input int p);
        while (exp_cnt[p] > 0) rd_beat(p, 32'hC0DE_0000 + 32'(exp_cnt[p]));
    endtask

    always @(negedge clk) begin
        if (!reset && arvalid && arready) begin
            check("ar_expected", exp_ar.size() != 0, 1);
            if (exp_ar.size() != 0) check("ar_beat", {arid, araddr, arsize}, exp_ar.pop_front());
        end
        if (!reset && awvalid && awready) begin
            check("aw_expected", exp_aw.size() != 0, 1);
            if (exp_aw.size() != 0) check("aw_beat", {awid, awaddr, awsize}, exp_aw.pop_front());
        end
        if (!reset && wvalid && wready) begin
            check("w_expected", exp_w.size() != 0, 1);
            if (exp_w.size() != 0) check("w_beat", {wid, wdata, wstrb, wlast}, exp_w.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        sram_req = '0; sram_wr = '0; sram_size = '0; sram_addr = '0; sram_wstrb = '0; sram_wdata = '0;
        arready = 1'b1; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b1; wready = 1'b1; bid = '0; bresp = '0; bvalid = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset / idle state
        @(negedge clk);
        check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
        check("rst_readys", {rready, bready}, 2'b11);
        check("rst_addr_ok", sram_addr_ok, 2'b00);
        check("rst_data_ok", sram_data_ok, 2'b00);
        check("const_axi", {arlen, awlen, arburst, awburst, wlast}, {4'd0, 4'd0, 2'b01, 2'b01, 1'b1});
        next_cycle();

        // Port1 single read and return
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'h0);
        @(negedge clk);
        check("p1_rd_addr_ok", sram_addr_ok, 2'b10);
        exp_read(1, 32'h0000_1000, 3'd2);
        next_cycle();
        sram_req = '0;
        @(negedge clk);
        check("p1_rd_arvalid", arvalid, 1'b1);
        next_cycle();
        rd_beat(1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("p1_arvalid_drop", arvalid, 1'b0);
        next_cycle();

        // Port0 hits the outstanding limit
        for (int k = 0; k < 4; k++) begin
            set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0100 + 32'(4*k), 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("p0_burst_ok%0d", k), sram_addr_ok, 2'b01);
            exp_read(0, 32'h0000_0100 + 32'(4*k), 3'd2);
            next_cycle();
        end
        set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0110, 4'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("p0_limit_block", sram_addr_ok, 2'b00);
            next_cycle();
        end
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678; rlast = 1'b1;
        @(negedge clk);
        check("p0_limit_ret_block", sram_addr_ok, 2'b00);
        check("p0_limit_ret_ok", sram_data_ok, 2'b01);
        exp_cnt[0]--;
        next_cycle();
        rvalid = 1'b0;
        @(negedge clk);
        check("p0_limit_release", sram_addr_ok, 2'b01);
        exp_read(0, 32'h0000_0110, 3'd2);
        next_cycle();
        sram_req = '0;
        rd_beat(3, 32'hBAD0_0003);
        drain(0);

        // Write pending blocks a same-word read; other words pass
        set_port(1, 1'b1, 1'b1, 2'd2, 32'h0000_2000, 4'hF, 32'h1122_3344);
        @(negedge clk);
        check("p1_wr_addr_ok", sram_addr_ok, 2'b10);
        exp_write(1, 32'h0000_2000, 3'd2, 4'hF, 32'h1122_3344);
        next_cycle();
        set_port(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        set_port(0, 1'b1, 1'b0, 2'd1, 32'h0000_2002, 4'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("raw_block", sram_addr_ok, 2'b00);
            next_cycle();
        end
        set_port(0, 1'b1, 1'b0, 2'd3, 32'h0000_3000, 4'h0, 32'h0);
        @(negedge clk);
        check("raw_other_ok", sram_addr_ok, 2'b01);
        exp_read(0, 32'h0000_3000, 3'd2);
        next_cycle();
        set_port(0, 1'b1, 1'b0, 2'd1, 32'h0000_2002, 4'h0, 32'h0);
        @(negedge clk);
        check("raw_block_again", sram_addr_ok, 2'b00);
        next_cycle();
        bvalid = 1'b1; bid = 4'd1;
        @(negedge clk);
        check("wr_b_data_ok", sram_data_ok, 2'b10);
        check("raw_block_bvalid", sram_addr_ok, 2'b00);
        next_cycle();
        bvalid = 1'b0;
        @(negedge clk);
        check("raw_release", sram_addr_ok, 2'b01);
        exp_read(0, 32'h0000_2002, 3'd1);
        next_cycle();
        sram_req = '0;
        drain(0);

        // Both ports read every cycle
`ifdef AXI_BRIDGE_RR_ARB_EN
        s5_n = 4;
        s5_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
`else
        s5_n = 5;
        s5_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`endif
        set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_4000, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 4'h0, 32'h0);
        for (int k = 0; k < s5_n; k++) begin
            @(negedge clk);
            check($sformatf("arb_grant%0d", k), sram_addr_ok, s5_g[k]);
            if (s5_g[k][1]) exp_read(1, 32'h0000_5000, 3'd2);
            else            exp_read(0, 32'h0000_4000, 3'd2);
            next_cycle();
        end
        sram_req = '0;
        drain(1);
        drain(0);

        // Delayed awready: W completes first, AW holds, data_ok only on B
        awready = 1'b0;
        set_port(0, 1'b1, 1'b1, 2'd1, 32'h0000_6000, 4'h3, 32'hA5A5_0001);
        @(negedge clk);
        check("p0_wr_addr_ok", sram_addr_ok, 2'b01);
        exp_write(0, 32'h0000_6000, 3'd1, 4'h3, 32'hA5A5_0001);
        next_cycle();
        set_port(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b1, 2'd2, 32'h0000_6100, 4'hF, 32'h0);
        @(negedge clk);
        check("aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("wr_busy_block", sram_addr_ok, 2'b00);
        next_cycle();
        sram_req = '0;
        @(negedge clk);
        check("w_dropped_aw_held", {awvalid, wvalid}, 2'b10);
        check("no_early_data_ok", sram_data_ok, 2'b00);
        next_cycle();
        @(negedge clk);
        check("aw_still_held", awvalid, 1'b1);
        next_cycle();
        awready = 1'b1;
        @(negedge clk);
        check("aw_held_at_ready", awvalid, 1'b1);
        next_cycle();
        @(negedge clk);
        check("aw_dropped", awvalid, 1'b0);
        check("no_data_ok_before_b", sram_data_ok, 2'b00);
        next_cycle();
        bvalid = 1'b1; bid = 4'd0;
        @(negedge clk);
        check("p0_b_data_ok", sram_data_ok, 2'b01);
        next_cycle();
        bvalid = 1'b0;

        // Reset with a read in flight; late R must be dropped
        arready = 1'b0;
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_7000, 4'h0, 32'h0);
        @(negedge clk);
        check("mid_rd_addr_ok", sram_addr_ok, 2'b10);
        next_cycle();
        sram_req = '0;
        @(negedge clk);
        check("mid_rd_arvalid", arvalid, 1'b1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        @(negedge clk);
        check("mid_rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
        next_cycle();
        arready = 1'b1;
        rd_beat(1, 32'h5151_5151);

        check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
        check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
        check("w_queue_empty", 64'(exp_w.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
